// File: rtl/tinyalu_pkg.sv
// Shared types for the tinyalu command path: opcodes, driver FSM states and
// the command record that travels through the command FIFO.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    OP_NOOP = 3'b000,
    OP_ADD  = 3'b001,
    OP_AND  = 3'b010,
    OP_XOR  = 3'b011,
    OP_MULT = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // op is kept as raw bits so that invalid encodings (5..7) survive the FIFO
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [3:0] tag;
  } cmd_t;

  // Opcodes that actually need the ALU
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_MULT);
  endfunction

  // Any opcode the ALU defines, including NO_OP
  function automatic logic is_valid_op(input logic [2:0] op);
    return (op == OP_NOOP) || is_alu_op(op);
  endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Synchronous FIFO for command records. DEPTH must be a power of two (>= 2)
// so that the read/write pointers wrap naturally. Push while full and pop
// while empty are ignored.
module tinyalu_cmd_fifo #(
  parameter int  DEPTH  = 4,
  parameter type data_t = logic [7:0]
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  data_t                      din,
  input  logic                       pop,
  output data_t                      dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  data_t         mem_q [DEPTH];
  data_t         mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next pointers, occupancy and storage contents
  always_comb begin
    count_d = count_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset empties the FIFO and discards contents
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/tinyalu_cmd_driver.sv
// Command front end for tinyalu: buffers commands, drives the ALU's
// start/done handshake with a timeout watchdog, and returns tagged results.
//
// Handshakes: cmd and rsp are valid/ready. A transfer happens on a rising
// edge where valid and ready are both high; valid never depends on ready, and
// rsp_result/rsp_tag/rsp_err stay stable while rsp_valid is high.
module tinyalu_cmd_driver
  import tinyalu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  input  logic [3:0]  cmd_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_tag,
  output logic        rsp_err,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        busy,
  output state_e      dbg_state
);

  localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int            WW        = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [7:0]    a_q, a_d;
  logic [7:0]    b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic          start_q, start_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [15:0]   result_q, result_d;
  logic [3:0]    tag_q, tag_d;
  logic          err_q, err_d;

  cmd_t          cmd_in;
  cmd_t          head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;

  assign cmd_in    = '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};
  assign cmd_ready = (fifo_count != CW'(FIFO_DEPTH));
  assign fifo_push = cmd_valid && !fifo_full;

  tinyalu_cmd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .data_t (cmd_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (cmd_in),
    .pop     (fifo_pop),
    .dout    (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; alu_done wins over the timeout in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = is_alu_op(head.op) ? ST_ISSUE : ST_RESP;
      ST_ISSUE: if (alu_done || (wait_q == WAIT_LAST)) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: FIFO pop, response valid, busy and state visibility
  always_comb begin
    fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    rsp_valid = (state_q == ST_RESP);
    busy      = (state_q != ST_IDLE) || !fifo_empty;
    dbg_state = state_q;
  end

  // Datapath next values: ALU operands on pop, result capture in ISSUE
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    start_d  = start_q;
    wait_d   = wait_q;
    result_d = result_q;
    tag_d    = tag_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          tag_d = head.tag;
          if (is_alu_op(head.op)) begin
            a_d     = head.a;
            b_d     = head.b;
            op_d    = head.op;
            start_d = 1'b1;
            wait_d  = '0;
          end else begin
            // NO_OP and invalid opcodes answer directly without the ALU
            result_d = 16'h0000;
            err_d    = !is_valid_op(head.op);
          end
        end
      end
      ST_ISSUE: begin
        wait_d = wait_q + WW'(1);
        if (alu_done) begin
          result_d = alu_result;
          err_d    = 1'b0;
          start_d  = 1'b0;
        end else if (wait_q == WAIT_LAST) begin
          result_d = 16'h0000;
          err_d    = 1'b1;
          start_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      start_q  <= 1'b0;
      wait_q   <= '0;
      result_q <= '0;
      tag_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      start_q  <= start_d;
      wait_q   <= wait_d;
      result_q <= result_d;
      tag_q    <= tag_d;
      err_q    <= err_d;
    end
  end

  assign alu_A      = a_q;
  assign alu_B      = b_q;
  assign alu_op     = op_q;
  assign alu_start  = start_q;
  assign rsp_result = result_q;
  assign rsp_tag    = tag_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_tinyalu_cmd_driver.sv
// Directed bench for tinyalu_cmd_driver with a small behavioural tinyalu
// that raises done after a programmable number of cycles of start.
module tb_tinyalu_cmd_driver;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic [7:0]  alu_A;
  logic [7:0]  alu_B;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // expected responses: {tag, err, result}
  logic [20:0] exp_q[$];

  tinyalu_cmd_driver #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .cmd_tag    (cmd_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: done pulses when start has been high for alu_lat edges (0 = never)
  int alu_lat = 1;
  int alu_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)       alu_cnt <= 0;
    else if (alu_start) alu_cnt <= alu_cnt + 1;
    else                alu_cnt <= 0;
  end
  assign alu_done = alu_start && (alu_lat != 0) && (alu_cnt == alu_lat);

  always_comb begin
    case (alu_op)
      3'b001:  alu_result = {8'h00, alu_A} + {8'h00, alu_B};
      3'b010:  alu_result = {8'h00, alu_A & alu_B};
      3'b011:  alu_result = {8'h00, alu_A ^ alu_B};
      3'b100:  alu_result = {8'h00, alu_A} * {8'h00, alu_B};
      default: alu_result = 16'h0000;
    endcase
  end

  // activity monitors
  logic start_seen;
  logic rsp_seen;
  always @(posedge clk) begin
    if (alu_start) start_seen = 1'b1;
    if (rsp_valid) rsp_seen   = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic [3:0] tag);
    int n;
    n = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("push_timeout", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 60) begin tick(); n++; end
    if (n >= 60) chk({tag, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!alu_start && n < 60) begin tick(); n++; end
    if (n >= 60) chk({tag, "_start_timeout"}, 32'(alu_start), 32'd1);
  endtask

  // counts cycles of alu_start high and whether the ALU inputs stayed put
  task automatic measure_start(output int hi, output logic stable);
    logic [18:0] snap;
    hi = 0;
    stable = 1'b1;
    snap = {alu_A, alu_B, alu_op};
    while (alu_start && hi < 64) begin
      if ({alu_A, alu_B, alu_op} !== snap) stable = 1'b0;
      hi++;
      tick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"},  32'(cmd_ready),  32'd1);
    chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    chk({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    chk({tag, "_rsp_tag"},    32'(rsp_tag),    32'd0);
    chk({tag, "_rsp_err"},    32'(rsp_err),    32'd0);
    chk({tag, "_alu_A"},      32'(alu_A),      32'd0);
    chk({tag, "_alu_B"},      32'(alu_B),      32'd0);
    chk({tag, "_alu_op"},     32'(alu_op),     32'd0);
    chk({tag, "_alu_start"},  32'(alu_start),  32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_state"},      32'(dbg_state),  32'd0);
  endtask

  initial begin
    int          hi;
    logic        stable;
    logic [20:0] e;

    reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    start_seen = 1'b0; rsp_seen = 1'b0;

    // reset values
    #1;
    check_reset_outputs("reset");
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // ADD 0F+01, done after 1 cycle
    alu_lat = 1;
    push(8'h0F, 8'h01, 3'b001, 4'd3);
    chk("add_start_not_yet", 32'(alu_start), 32'd0);
    chk("add_busy_queued",   32'(busy),      32'd1);
    tick();
    chk("add_start_rise", 32'(alu_start), 32'd1);
    chk("add_alu_op",     32'(alu_op),    32'd1);
    chk("add_alu_ab",     32'({alu_A, alu_B}), 32'h0F01);
    measure_start(hi, stable);
    chk("add_start_cycles", 32'(hi),        32'd2);
    chk("add_stable",       32'(stable),    32'd1);
    chk("add_rsp_valid",    32'(rsp_valid), 32'd1);
    chk("add_rsp_result",   32'(rsp_result), 32'h0010);
    chk("add_rsp_tag",      32'(rsp_tag),   32'd3);
    chk("add_rsp_err",      32'(rsp_err),   32'd0);
    chk("add_state_resp",   32'(dbg_state), 32'd2);
    tick();
    chk("add_rsp_held",     32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("add_rsp_done",     32'(rsp_valid), 32'd0);
    chk("add_idle_busy",    32'(busy),      32'd0);

    // MUL FF*FF, done after 3 cycles
    alu_lat = 3;
    push(8'hFF, 8'hFF, 3'b100, 4'd5);
    wait_start("mul");
    measure_start(hi, stable);
    chk("mul_start_cycles", 32'(hi),         32'd4);
    chk("mul_stable",       32'(stable),     32'd1);
    chk("mul_rsp_valid",    32'(rsp_valid),  32'd1);
    chk("mul_rsp_result",   32'(rsp_result), 32'hFE01);
    chk("mul_rsp_tag",      32'(rsp_tag),    32'd5);
    chk("mul_rsp_err",      32'(rsp_err),    32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // NO_OP then invalid op 110: no ALU activity, responses in order
    start_seen = 1'b0;
    push(8'h12, 8'h34, 3'b000, 4'd6);
    push(8'h56, 8'h78, 3'b110, 4'd7);
    wait_rsp("noop");
    chk("noop_result", 32'(rsp_result), 32'h0000);
    chk("noop_err",    32'(rsp_err),    32'd0);
    chk("noop_tag",    32'(rsp_tag),    32'd6);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    wait_rsp("badop");
    chk("badop_result", 32'(rsp_result), 32'h0000);
    chk("badop_err",    32'(rsp_err),    32'd1);
    chk("badop_tag",    32'(rsp_tag),    32'd7);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    chk("noop_no_start", 32'(start_seen), 32'd0);

    // five ADDs while responses are blocked: FIFO fills, then drains in order
    alu_lat = 1;
    push(8'h10, 8'h01, 3'b001, 4'd8);  exp_q.push_back({4'd8,  1'b0, 16'h0011});
    push(8'h20, 8'h01, 3'b001, 4'd9);  exp_q.push_back({4'd9,  1'b0, 16'h0021});
    push(8'h30, 8'h01, 3'b001, 4'd10); exp_q.push_back({4'd10, 1'b0, 16'h0031});
    push(8'h40, 8'h01, 3'b001, 4'd11); exp_q.push_back({4'd11, 1'b0, 16'h0041});
    chk("fill_ready_before_5th", 32'(cmd_ready), 32'd1);
    push(8'h50, 8'h01, 3'b001, 4'd12); exp_q.push_back({4'd12, 1'b0, 16'h0051});
    chk("fill_ready_dropped", 32'(cmd_ready), 32'd0);
    repeat (5) tick();
    chk("fill_ready_still_low", 32'(cmd_ready), 32'd0);
    chk("fill_busy",            32'(busy),      32'd1);
    rsp_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_rsp("drain");
      chk("drain_tag",    32'(rsp_tag),    32'(e[20:17]));
      chk("drain_err",    32'(rsp_err),    32'(e[16]));
      chk("drain_result", 32'(rsp_result), 32'(e[15:0]));
      tick();
    end
    rsp_ready = 1'b0;
    chk("drain_ready_back", 32'(cmd_ready), 32'd1);

    // ALU never answers: watchdog after 16 cycles, then normal XOR
    alu_lat = 0;
    push(8'h01, 8'h02, 3'b001, 4'd13);
    wait_start("tmo");
    measure_start(hi, stable);
    chk("tmo_start_cycles", 32'(hi),         32'd16);
    chk("tmo_rsp_valid",    32'(rsp_valid),  32'd1);
    chk("tmo_rsp_err",      32'(rsp_err),    32'd1);
    chk("tmo_rsp_result",   32'(rsp_result), 32'h0000);
    chk("tmo_rsp_tag",      32'(rsp_tag),    32'd13);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    alu_lat = 1;
    push(8'hF0, 8'hFF, 3'b011, 4'd14);
    wait_start("xor");
    measure_start(hi, stable);
    chk("xor_start_cycles", 32'(hi),         32'd2);
    chk("xor_rsp_result",   32'(rsp_result), 32'h000F);
    chk("xor_rsp_err",      32'(rsp_err),    32'd0);
    chk("xor_rsp_tag",      32'(rsp_tag),    32'd14);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // asynchronous reset during a long MUL with another command queued
    alu_lat = 10;
    push(8'h02, 8'h03, 3'b100, 4'd15);
    push(8'h04, 8'h05, 3'b001, 4'd1);
    wait_start("rst");
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick(); tick();
    reset_n = 1'b1;
    start_seen = 1'b0;
    rsp_seen   = 1'b0;
    repeat (20) tick();
    chk("postrst_no_start", 32'(start_seen), 32'd0);
    chk("postrst_no_rsp",   32'(rsp_seen),   32'd0);
    chk("postrst_busy",     32'(busy),       32'd0);
    chk("postrst_ready",    32'(cmd_ready),  32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
